// File: rtl/svc_rv_run_ctrl_pkg.sv
// Shared types for the SoC run controller.
// state_t  : controller phase.
// status_t : reason the last run ended; tops reuse these codes for LED/UART reporting.
package svc_rv_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    EBREAK  = 3'd1,
    TRAP    = 3'd2,
    TIMEOUT = 3'd3,
    ABORT   = 3'd4
  } status_t;

endpackage

// File: rtl/svc_rv_soc_run_ctrl.sv
// Run controller for one RISC-V SoC instance: holds the core in reset,
// releases it, counts run cycles and records why the run stopped.
// Ports:
//   clk, rst_n          controller clock and async active-low reset
//   start, abort        launch (IDLE/HALT) and force-stop (RESET/RUN) requests
//   core_rst_n          registered active-low reset to the SoC
//   core_ebreak/trap    SoC halt indications, sampled only in RUN
//   busy, done          RESET/RUN and HALT indicators
//   status              status_t exit reason
//   cycles              RUN cycles of the last or current run (saturating)
module svc_rv_soc_run_ctrl
  import svc_rv_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             core_rst_n,
  input  logic             core_ebreak,
  input  logic             core_trap,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [7:0]       HOLD_INIT = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q,  state_d;
  status_t          status_q, status_d;
  logic [7:0]       hold_q,   hold_d;
  logic [CNT_W-1:0] cyc_q,    cyc_d;
  logic             core_q,   core_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [CNT_W-1:0] cyc_inc;
  logic             timeout_hit;

  always_comb begin
    cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    // Compared pre-increment so the exit cycle itself is counted.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_q == TO_LAST);

    state_d  = state_q;
    status_d = status_q;
    hold_d   = hold_q;
    cyc_d    = cyc_q;
    core_d   = core_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d  = RESET;
          hold_d   = HOLD_INIT;
          cyc_d    = '0;
          status_d = NONE;
          core_d   = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RESET: begin
        if (abort) begin
          state_d  = HALT;
          status_d = ABORT;
          core_d   = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (hold_q == 8'd0) begin
          state_d = RUN;
          core_d  = 1'b1;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      RUN: begin
        cyc_d = cyc_inc;
        if (abort || core_trap || core_ebreak || timeout_hit) begin
          state_d = HALT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // EBREAK/TRAP leave the core out of reset so its state stays inspectable.
          if (abort) begin
            status_d = ABORT;
            core_d   = 1'b0;
          end else if (core_trap) begin
            status_d = TRAP;
          end else if (core_ebreak) begin
            status_d = EBREAK;
          end else begin
            status_d = TIMEOUT;
            core_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        core_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= NONE;
      hold_q   <= '0;
      cyc_q    <= '0;
      core_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      hold_q   <= hold_d;
      cyc_q    <= cyc_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign core_rst_n = core_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign cycles     = cyc_q;

endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
module tb_svc_rv_soc_run_ctrl;

  localparam int unsigned R = 4;
  localparam int unsigned T = 20;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         core_ebreak = 1'b0;
  logic         core_trap = 1'b0;
  logic         core_rst_n;
  logic         busy;
  logic         done;
  logic [2:0]   status;
  logic [W-1:0] cycles;

  int errors = 0;
  int checks = 0;

  // Behavioural model: expected outputs after each edge.
  logic         m_busy, m_done, m_core;
  logic [2:0]   m_stat;
  logic [W-1:0] m_cyc;
  int           rst_left;

  svc_rv_soc_run_ctrl #(
    .RST_CYCLES(R),
    .CNT_W(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .core_rst_n(core_rst_n),
    .core_ebreak(core_ebreak),
    .core_trap(core_trap),
    .busy(busy),
    .done(done),
    .status(status),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_core   = 1'b0;
    m_stat   = 3'd0;
    m_cyc    = '0;
    rst_left = 0;
  endtask

  task automatic model_halt(input logic [2:0] why, input logic core_on);
    m_busy = 1'b0;
    m_done = 1'b1;
    m_stat = why;
    m_core = core_on;
  endtask

  task automatic model_edge();
    logic [W-1:0] prev;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (start) begin
        m_busy   = 1'b1;
        m_done   = 1'b0;
        m_core   = 1'b0;
        m_stat   = 3'd0;
        m_cyc    = '0;
        rst_left = R;
      end
    end else if (rst_left > 0) begin
      if (abort) begin
        rst_left = 0;
        model_halt(3'd4, 1'b0);
      end else begin
        rst_left--;
        if (rst_left == 0) m_core = 1'b1;
      end
    end else begin
      prev = m_cyc;
      if (m_cyc != {W{1'b1}}) m_cyc = m_cyc + 1;
      if (abort)                        model_halt(3'd4, 1'b0);
      else if (core_trap)               model_halt(3'd2, 1'b1);
      else if (core_ebreak)             model_halt(3'd1, 1'b1);
      else if (T != 0 && prev == T - 1) model_halt(3'd3, 1'b0);
    end
  endtask

  task automatic compare();
    chk("core_rst_n", core_rst_n, m_core);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("status", status, m_stat);
    chk("cycles", cycles, m_cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    steps(2);
    chk("reset_core_rst_n", core_rst_n, 1'b0);
    chk("reset_cycles", cycles, 0);
    rst_n = 1'b1;

    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_done", done, 1'b0);

    // start at edge 0: core_rst_n low cycles 1..4, high at cycle 5
    launch();
    chk("launch_busy", busy, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("hold_low", core_rst_n, 1'b0);
      step();
    end
    chk("release_high", core_rst_n, 1'b1);
    // in RUN cycle 1; start in RUN cycle 3 must be ignored
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    steps(6);
    core_ebreak = 1'b1;
    step();
    core_ebreak = 1'b0;
    chk("ebreak_done", done, 1'b1);
    chk("ebreak_status", status, 3'd1);
    chk("ebreak_cycles", cycles, 10);
    chk("ebreak_core", core_rst_n, 1'b1);

    // relaunch from HALT, ebreak/trap during RESET ignored, then timeout
    launch();
    chk("relaunch_done", done, 1'b0);
    chk("relaunch_busy", busy, 1'b1);
    chk("relaunch_cycles", cycles, 0);
    chk("relaunch_status", status, 3'd0);
    core_ebreak = 1'b1;
    core_trap   = 1'b1;
    steps(4);
    core_ebreak = 1'b0;
    core_trap   = 1'b0;
    chk("reset_ignores_halt", busy, 1'b1);
    chk("reset_ignores_core", core_rst_n, 1'b1);
    steps(19);
    chk("pre_timeout_busy", busy, 1'b1);
    step();
    chk("timeout_status", status, 3'd3);
    chk("timeout_cycles", cycles, 20);
    chk("timeout_core", core_rst_n, 1'b0);
    chk("timeout_done", done, 1'b1);

    // trap beats ebreak
    launch();
    steps(4 + 2);
    core_trap   = 1'b1;
    core_ebreak = 1'b1;
    step();
    core_trap   = 1'b0;
    core_ebreak = 1'b0;
    chk("trap_status", status, 3'd2);
    chk("trap_cycles", cycles, 3);
    chk("trap_core", core_rst_n, 1'b1);

    // abort beats trap
    launch();
    steps(4 + 4);
    abort     = 1'b1;
    core_trap = 1'b1;
    step();
    abort     = 1'b0;
    core_trap = 1'b0;
    chk("abort_status", status, 3'd4);
    chk("abort_cycles", cycles, 5);
    chk("abort_core", core_rst_n, 1'b0);

    // abort in RESET
    launch();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("rst_abort_status", status, 3'd4);
    chk("rst_abort_cycles", cycles, 0);
    chk("rst_abort_done", done, 1'b1);

    // start+abort in HALT: start wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins_busy", busy, 1'b1);
    chk("start_wins_status", status, 3'd0);

    // global reset mid-RUN acts immediately
    steps(6);
    chk("midrun_core", core_rst_n, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_core", core_rst_n, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_cycles", cycles, 0);
    compare();
    @(negedge clk);
    steps(1);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      core_ebreak = ($urandom_range(0, 14) == 0);
      core_trap   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svc_rv_soc_run_ctrl.md
Name: svc_rv_soc_run_ctrl

Overview:
Run controller that sequences one RISC-V SoC instance (svc_rv_soc_sram/bram family) through reset, run and halt. It drives the SoC's rst_n and watches its ebreak and trap outputs. It measures run length in cycles and reports why the run ended. Its purpose is to let demo tops and benches launch, re-launch, abort and time-limit programs without toggling the global reset.

Parameters:
RST_CYCLES, 4, cycles core_rst_n is held low after start; legal range 1..255.
CNT_W, 32, width of the run-cycle counter.
TIMEOUT_CYCLES, 0, run limit in RUN cycles; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset for the controller
start  input  1  launch request; honoured in IDLE or HALT only
abort  input  1  force-stop request; honoured in RESET or RUN
core_rst_n  output  1  registered reset to the SoC, active-low
core_ebreak  input  1  SoC ebreak
core_trap  input  1  SoC trap
busy  output  1  high in RESET and RUN
done  output  1  high in HALT; level
status  output  3  0 NONE, 1 EBREAK, 2 TRAP, 3 TIMEOUT, 4 ABORT
cycles  output  CNT_W  RUN cycles of the last or current run

Behaviour:
- Reset is asynchronous: state=IDLE, core_rst_n=0, busy=0, done=0, status=NONE, cycles=0, reset-hold counter=0.
- All outputs are registered and change only on clk edges.
- IDLE: core_rst_n=0. start -> RESET; load the hold counter with RST_CYCLES-1; clear cycles; status=NONE.
- RESET: core_rst_n=0 for exactly RST_CYCLES cycles.
  - abort -> HALT with status=ABORT.
  - Otherwise, when the hold counter reaches 0 -> RUN.
  - core_ebreak and core_trap are ignored in this state.
- RUN: core_rst_n=1. Each cycle, cycles <= cycles+1, saturating at all-ones.
- Exit checks in RUN, evaluated on the same cycle, fixed priority abort > trap > ebreak > timeout:
  - abort -> HALT, status=ABORT.
  - core_trap -> HALT, status=TRAP.
  - core_ebreak -> HALT, status=EBREAK.
  - TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 (pre-increment) -> HALT, status=TIMEOUT.
  - The exit cycle itself is counted. An ebreak on the first RUN cycle gives cycles=1.
- HALT: done=1; cycles and status are frozen.
  - status EBREAK or TRAP: core_rst_n stays 1 so the frozen core state and IO remain inspectable.
  - status TIMEOUT or ABORT: core_rst_n=0 from the first HALT cycle.
  - start -> RESET, same as from IDLE (re-launch). done falls and busy rises on that same edge.
- Ignored requests:
  - start in RESET or RUN.
  - abort in IDLE or HALT.
  - start and abort together in IDLE or HALT: start wins, because abort is not honoured there.
- Latency, start seen at edge k:
  - core_rst_n low during cycles k+1..k+RST_CYCLES.
  - core_rst_n high from cycle k+RST_CYCLES+1.
  - A halt event sampled at edge m gives done=1 from cycle m+1.
- Counter saturation does not end the run. Only the four exit checks do.
- Asserting global rst_n mid-run returns to IDLE immediately and drives core_rst_n=0 asynchronously.

Decomposition:
- Package svc_rv_run_ctrl_pkg holds two typedefs:
  - state_t enum {IDLE, RESET, RUN, HALT}
  - status_t 3-bit enum {NONE, EBREAK, TRAP, TIMEOUT, ABORT}
- Tops use the status_t encodings for LED/UART reporting.
- No sub-module is needed. The hold counter and saturating run counter live inline in the FSM's sequential block.
- The demo top instantiates this block beside the SoC and wires core_rst_n to the SoC's rst_n.

Test Plan:
- Reset, then start at edge 0 with RST_CYCLES=4 -> core_rst_n low for cycles 1-4 and high at cycle 5; busy=1 from cycle 1.
- core_ebreak raised on the 10th RUN cycle -> next cycle done=1, status=1, cycles=10, core_rst_n stays 1.
- TIMEOUT_CYCLES=20 with no ebreak -> HALT after 20 RUN cycles, status=3, cycles=20, core_rst_n=0.
- core_trap and core_ebreak in the same RUN cycle -> status=2. In a separate run, abort with trap in the same cycle -> status=4.
- start during RUN is ignored. start in HALT re-launches: done falls, cycles clears, status returns to 0.
- rst_n pulsed low mid-RUN -> immediate IDLE, core_rst_n=0, cycles=0, busy=0; core_ebreak and core_trap asserted during RESET have no effect.
